// File: rtl/pdp8lpplay_pkg.sv
// Shared constants, register layout and threshold helper for the pdp8lpplay pulse-stream player.
package pdp8lpplay_pkg;

  localparam int unsigned PP_REG_IDENT = 0;
  localparam int unsigned PP_REG_CTL   = 1;
  localparam int unsigned PP_REG_DATA  = 2;
  localparam int unsigned PP_REG_STAT  = 3;

  localparam logic [31:0] PP_IDENT        = 32'h50502001;
  localparam logic [31:0] PP_FILLER       = 32'hDEADBEEF;
  localparam logic [15:0] PP_SAMPRATE_DEF = 16'd12499;

  typedef struct packed {
    logic        enable;
    logic        uflow;
    logic        oflow;
    logic [4:0]  count;
    logic [7:0]  rsvd;
    logic [15:0] samprate;
  } pp_ctl_t;

  // PWM high time in clocks for one sample: (sample * (samprate+1)) >> 8 on a 24-bit product
  function automatic logic [15:0] pp_thresh(input logic [7:0] samp, input logic [15:0] rate);
    logic [23:0] prod;
    prod = 24'(samp) * (24'(rate) + 24'd1);
    return prod[23:8];
  endfunction

endpackage

// File: rtl/pdp8lpplay_if.sv
// ARM register bus for the pdp8lpplay player.
interface pdp8lpplay_if;
  logic        armwrite;
  logic [2:0]  armraddr;
  logic [2:0]  armwaddr;
  logic [31:0] armwdata;
  logic [31:0] armrdata;

  modport master (output armwrite, armraddr, armwaddr, armwdata, input armrdata);
  modport slave  (input armwrite, armraddr, armwaddr, armwdata, output armrdata);
endinterface

// File: rtl/pdp8lpplay_fifo.sv
// Synchronous 32-bit word FIFO, 2^DEPTHLG2 deep; push on full and pop on empty are ignored.
module pdp8lpplay_fifo #(
  parameter int unsigned DEPTHLG2 = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [31:0]         wdata_i,
  output logic [31:0]         rdata_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [DEPTHLG2:0]   count_o
);

  localparam int unsigned DEPTH = 1 << DEPTHLG2;

  logic [31:0]         mem_q [DEPTH];
  logic [DEPTHLG2-1:0] wptr_q, rptr_q;
  logic [DEPTHLG2:0]   count_q;
  logic                do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (DEPTHLG2+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // A push into a full FIFO is still taken when a pop frees the slot in the same cycle
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + DEPTHLG2'(1);
      if (do_pop)  rptr_q <= rptr_q + DEPTHLG2'(1);
      count_q <= count_q + (DEPTHLG2+1)'(do_push) - (DEPTHLG2+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pdp8lpplay.sv
// Pulse-stream player: unpacks FIFO bytes MSB-first at a programmed rate into a PWM pulse.
// Optional refill flag built only with PDP8LPPLAY_LOWWATER_EN.
module pdp8lpplay
  import pdp8lpplay_pkg::*;
#(
  parameter int unsigned DEPTHLG2 = 4
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              CSTEP,
  pdp8lpplay_if.slave       arm,
  output logic              pulse,
  output logic              lowwater
);

  logic        enable_q, enable_d;
  logic        uflow_q, uflow_d;
  logic        oflow_q, oflow_d;
  logic [15:0] samprate_q, samprate_d;
  logic [15:0] phase_q, phase_d;
  logic [1:0]  byteidx_q, byteidx_d;
  logic [15:0] thresh_q, thresh_d;
  logic        pulse_q, pulse_d;
  logic [15:0] ucount_q, ucount_d;
  logic [15:0] played_q, played_d;

  logic [31:0]       fifo_rdata;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [DEPTHLG2:0] fifo_count;
  logic              wr_ctl, wr_data, run, load;
  logic [7:0]        cur_byte;
  pp_ctl_t           ctl_rd;

  assign wr_ctl   = arm.armwrite && (arm.armwaddr == 3'(PP_REG_CTL));
  assign wr_data  = arm.armwrite && (arm.armwaddr == 3'(PP_REG_DATA));
  assign run      = CSTEP & enable_q & ~arm.armwrite;
  assign load     = run && (phase_q == 16'd0);
  assign cur_byte = 8'(fifo_rdata >> {~byteidx_q, 3'b000});
  assign fifo_pop = load && !fifo_empty && (byteidx_q == 2'd3);

  pdp8lpplay_fifo #(.DEPTHLG2(DEPTHLG2)) u_fifo (
    .clk     (CLOCK),
    .rst_n   (RESET_N),
    .push_i  (wr_data),
    .pop_i   (fifo_pop),
    .wdata_i (arm.armwdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    enable_d   = enable_q;
    uflow_d    = uflow_q;
    oflow_d    = oflow_q;
    samprate_d = samprate_q;
    phase_d    = phase_q;
    byteidx_d  = byteidx_q;
    thresh_d   = thresh_q;
    pulse_d    = pulse_q;
    ucount_d   = ucount_q;
    played_d   = played_q;

    if (wr_ctl) begin
      enable_d   = arm.armwdata[31];
      samprate_d = arm.armwdata[15:0];
      if (arm.armwdata[30]) uflow_d = 1'b0;
      if (arm.armwdata[29]) oflow_d = 1'b0;
      phase_d = 16'd0;
      pulse_d = 1'b0;
    end
    if (wr_data && fifo_full && !fifo_pop) oflow_d = 1'b1;

    if (run) begin
      phase_d = (phase_q == samprate_q) ? 16'd0 : phase_q + 16'd1;
      if (load) begin
        // Starved: play silence and keep byteidx so the next word starts at its MSB
        if (fifo_empty) begin
          thresh_d = 16'd0;
          uflow_d  = 1'b1;
          if (ucount_q != 16'hFFFF) ucount_d = ucount_q + 16'd1;
        end else begin
          thresh_d  = pp_thresh(cur_byte, samprate_q);
          byteidx_d = byteidx_q + 2'd1;
          played_d  = played_q + 16'd1;
        end
      end
      pulse_d = (phase_q < thresh_d);
    end else if (!enable_q) begin
      pulse_d = 1'b0;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      enable_q   <= 1'b0;
      uflow_q    <= 1'b0;
      oflow_q    <= 1'b0;
      samprate_q <= PP_SAMPRATE_DEF;
      phase_q    <= 16'd0;
      byteidx_q  <= 2'd0;
      thresh_q   <= 16'd0;
      pulse_q    <= 1'b0;
      ucount_q   <= 16'd0;
      played_q   <= 16'd0;
    end else begin
      enable_q   <= enable_d;
      uflow_q    <= uflow_d;
      oflow_q    <= oflow_d;
      samprate_q <= samprate_d;
      phase_q    <= phase_d;
      byteidx_q  <= byteidx_d;
      thresh_q   <= thresh_d;
      pulse_q    <= pulse_d;
      ucount_q   <= ucount_d;
      played_q   <= played_d;
    end
  end

  assign pulse = pulse_q;

  always_comb begin
    ctl_rd.enable   = enable_q;
    ctl_rd.uflow    = uflow_q;
    ctl_rd.oflow    = oflow_q;
    ctl_rd.count    = 5'(fifo_count);
    ctl_rd.rsvd     = 8'd0;
    ctl_rd.samprate = samprate_q;
    case (arm.armraddr)
      3'(PP_REG_IDENT): arm.armrdata = PP_IDENT;
      3'(PP_REG_CTL):   arm.armrdata = ctl_rd;
      3'(PP_REG_DATA):  arm.armrdata = fifo_empty ? 32'd0 : fifo_rdata;
      3'(PP_REG_STAT):  arm.armrdata = {ucount_q, played_q};
      default:          arm.armrdata = PP_FILLER;
    endcase
  end

`ifdef PDP8LPPLAY_LOWWATER_EN
  localparam int unsigned HALF = 1 << (DEPTHLG2 - 1);
  logic lowwater_q;

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) lowwater_q <= 1'b0;
    else          lowwater_q <= (fifo_count <= (DEPTHLG2+1)'(HALF));
  end

  assign lowwater = lowwater_q;
`else
  assign lowwater = 1'b0;
`endif

endmodule
